// File: rtl/serial_bit_tx.sv
// MSB-first serial bit transmitter with valid/ready load, optional inter-frame gap,
// synchronous abort and a per-bit "prefix divisible by 4" flag for scoring receivers.
module serial_bit_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             nextBit,
  output logic             bitValid,
  output logic             frameStart,
  output logic             frameEnd,
  output logic             busy,
  output logic             expDiv
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LOAD = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic              prev_q, prev_d;
  logic              last_bit, gap_done, take;

  assign last_bit = (cnt_q == LAST_IDX);
  assign gap_done = (gcnt_q == 4'd0);

  always_comb begin
    load_ready = 1'b0;
    unique case (state_q)
      S_IDLE:  load_ready = 1'b1;
      S_SHIFT: load_ready = last_bit && (GAP == 0);
      S_GAP:   load_ready = gap_done;
      default: load_ready = 1'b0;
    endcase
  end

  // abort outranks a coincident handshake everywhere except IDLE
  assign take = load_valid && load_ready && (!abort || (state_q == S_IDLE));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    prev_d  = prev_q;
    if (take) begin
      state_d = S_SHIFT;
      sh_d    = load_data;
      cnt_d   = '0;
      prev_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q + CW'(1);
            prev_d = sh_q[WIDTH-1];
            if (last_bit) begin
              cnt_d = '0;
              if (GAP == 0) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_GAP;
                gcnt_d  = GAP_LOAD;
              end
            end
          end
        end
        S_GAP: begin
          if (abort || gap_done) state_d = S_IDLE;
          else                   gcnt_d  = gcnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      prev_q  <= prev_d;
    end
  end

  assign bitValid   = (state_q == S_SHIFT);
  assign nextBit    = bitValid && sh_q[WIDTH-1];
  assign frameStart = bitValid && (cnt_q == '0);
  assign frameEnd   = bitValid && last_bit;
  assign busy       = (state_q != S_IDLE);
  // prev_q is cleared on every load, so the first bit of a frame sees prev = 0
  assign expDiv     = bitValid && !sh_q[WIDTH-1] && !prev_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: three instances (W8/G0, W8/G3, W2/G0) share
// clock and reset; a negedge monitor pops expected bit records pushed at each handshake.
module tb_serial_bit_tx;

  logic CLK, RESET;

  logic       lv0, ab0, lr0, nb0, bv0, fs0, fe0, by0, ed0;
  logic [7:0] ld0;
  logic       lv1, ab1, lr1, nb1, bv1, fs1, fe1, by1, ed1;
  logic [7:0] ld1;
  logic       lv2, ab2, lr2, nb2, bv2, fs2, fe2, by2, ed2;
  logic [1:0] ld2;

  serial_bit_tx #(.WIDTH(8), .GAP(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
    .abort(ab0), .nextBit(nb0), .bitValid(bv0), .frameStart(fs0), .frameEnd(fe0),
    .busy(by0), .expDiv(ed0));

  serial_bit_tx #(.WIDTH(8), .GAP(3)) dut1 (
    .CLK(CLK), .RESET(RESET), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
    .abort(ab1), .nextBit(nb1), .bitValid(bv1), .frameStart(fs1), .frameEnd(fe1),
    .busy(by1), .expDiv(ed1));

  serial_bit_tx #(.WIDTH(2), .GAP(0)) dut2 (
    .CLK(CLK), .RESET(RESET), .load_valid(lv2), .load_data(ld2), .load_ready(lr2),
    .abort(ab2), .nextBit(nb2), .bitValid(bv2), .frameStart(fs2), .frameEnd(fe2),
    .busy(by2), .expDiv(ed2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // record = {bit, frameStart, frameEnd, expDiv}
  logic [3:0] exp_q [3][$];
  int checks = 0;
  int errors = 0;

  task automatic push_word(input int inst, input logic [31:0] w, input int width);
    int v;
    logic [3:0] r;
    v = 0;
    for (int i = width - 1; i >= 0; i--) begin
      v = ((v * 2) + int'(w[i])) % 4;   // prefix value mod 4
      r = {w[i], (i == width - 1), (i == 0), (v == 0)};
      exp_q[inst].push_back(r);
    end
  endtask

  task automatic mon(input int inst, input logic bv, input logic [3:0] got, input logic ab,
                     input logic by, input logic lv, input logic lr, input logic [31:0] ld,
                     input int width);
    logic [3:0] e;
    checks++;
    if (bv) begin
      if (exp_q[inst].size() == 0) begin
        errors++;
        $display("FAIL bit_stream%0d unexpected bit {bit,fs,fe,ed}=%b, expected no bit", inst, got);
      end else begin
        e = exp_q[inst].pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL bit_stream%0d got {bit,fs,fe,ed}=%b expected %b", inst, got, e);
        end
      end
    end else if (got !== 4'b0000) begin
      errors++;
      $display("FAIL idle_strobes%0d got {bit,fs,fe,ed}=%b expected 0000", inst, got);
    end
    if (ab && by) exp_q[inst].delete();
    if (lv && lr && !(ab && by)) push_word(inst, ld, width);
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      mon(0, bv0, {nb0, fs0, fe0, ed0}, ab0, by0, lv0, lr0, 32'(ld0), 8);
      mon(1, bv1, {nb1, fs1, fe1, ed1}, ab1, by1, lv1, lr1, 32'(ld1), 8);
      mon(2, bv2, {nb2, fs2, fe2, ed2}, ab2, by2, lv2, lr2, 32'(ld2), 2);
    end
  end

  task automatic chk(input string name, input logic got, input logic expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, expv);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    lv0 = 0; ab0 = 0; ld0 = '0;
    lv1 = 0; ab1 = 0; ld1 = '0;
    lv2 = 0; ab2 = 0; ld2 = '0;
    #2;
    chk("rst_bitValid", bv0, 1'b0);
    chk("rst_nextBit", nb0, 1'b0);
    chk("rst_busy0", by0, 1'b0);
    chk("rst_busy1", by1, 1'b0);
    chk("rst_expDiv", ed0, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("post_rst_ready0", lr0, 1'b1);
    chk("post_rst_ready1", lr1, 1'b1);
    chk("post_rst_ready2", lr2, 1'b1);

    // single word B4
    lv0 = 1; ld0 = 8'hB4;
    cyc();
    lv0 = 0; ld0 = 8'h5A;
    chk("t1_first_fs", fs0, 1'b1);
    chk("t1_first_bv", bv0, 1'b1);
    chk("t1_first_bit", nb0, 1'b1);
    chk("t1_first_ready", lr0, 1'b0);
    repeat (7) cyc();
    chk("t1_last_fe", fe0, 1'b1);
    chk("t1_last_ed", ed0, 1'b1);
    chk("t1_last_ready", lr0, 1'b1);
    cyc();
    chk("t1_idle_busy", by0, 1'b0);
    chk("t1_idle_bv", bv0, 1'b0);
    chk("t1_idle_ready", lr0, 1'b1);

    // back-to-back FF then 00
    lv0 = 1; ld0 = 8'hFF;
    cyc();
    ld0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("t2_f1_bv", bv0, 1'b1);
      chk("t2_f1_ready", lr0, (i == 7));
      if (i < 7) cyc();
    end
    cyc();
    lv0 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_f2_bv", bv0, 1'b1);
      chk("t2_f2_ready", lr0, (i == 7));
      chk("t2_f2_ed", ed0, 1'b1);
      cyc();
    end
    chk("t2_idle_busy", by0, 1'b0);

    // GAP=3: 01 then 80
    lv1 = 1; ld1 = 8'h01;
    cyc();
    ld1 = 8'h80;
    for (int i = 0; i < 8; i++) begin
      chk("t3_f1_bv", bv1, 1'b1);
      chk("t3_f1_ready", lr1, 1'b0);
      cyc();
    end
    for (int g = 0; g < 3; g++) begin
      chk("t3_gap_bv", bv1, 1'b0);
      chk("t3_gap_bit", nb1, 1'b0);
      chk("t3_gap_busy", by1, 1'b1);
      chk("t3_gap_ready", lr1, (g == 2));
      if (g < 2) cyc();
    end
    cyc();
    lv1 = 0;
    chk("t3_f2_fs", fs1, 1'b1);
    chk("t3_f2_bit", nb1, 1'b1);
    repeat (8) cyc();
    chk("t3_gap2_busy", by1, 1'b1);
    repeat (3) cyc();
    chk("t3_idle_busy", by1, 1'b0);
    chk("t3_idle_ready", lr1, 1'b1);

    // abort at bit 3 of AA with a coincident load attempt
    lv0 = 1; ld0 = 8'hAA;
    cyc();
    lv0 = 0;
    repeat (3) cyc();
    chk("t4_bit3_bv", bv0, 1'b1);
    ab0 = 1; lv0 = 1; ld0 = 8'h3C;
    cyc();
    ab0 = 0; lv0 = 0;
    chk("t4_after_bv", bv0, 1'b0);
    chk("t4_after_busy", by0, 1'b0);
    chk("t4_after_ready", lr0, 1'b1);
    // abort while idle must not block this handshake
    ab0 = 1; lv0 = 1; ld0 = 8'hC3;
    cyc();
    ab0 = 0; lv0 = 0;
    chk("t4_restart_fs", fs0, 1'b1);
    chk("t4_restart_msb", nb0, 1'b1);
    repeat (8) cyc();
    chk("t4_idle_busy", by0, 1'b0);

    // asynchronous reset mid-frame at bit 5
    lv0 = 1; ld0 = 8'hE7;
    cyc();
    lv0 = 0;
    repeat (5) cyc();
    chk("t5_bit5_bv", bv0, 1'b1);
    #3;
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    #1;
    chk("t5_rst_bv", bv0, 1'b0);
    chk("t5_rst_bit", nb0, 1'b0);
    chk("t5_rst_fs", fs0, 1'b0);
    chk("t5_rst_fe", fe0, 1'b0);
    chk("t5_rst_busy", by0, 1'b0);
    chk("t5_rst_ed", ed0, 1'b0);
    cyc();
    RESET = 1'b0;
    chk("t5_rel_ready", lr0, 1'b1);
    lv0 = 1; ld0 = 8'h0C;
    cyc();
    lv0 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_0C_ed", ed0, (i <= 3) || (i == 7));
      cyc();
    end
    chk("t5_idle_busy", by0, 1'b0);

    // WIDTH=2 random-valid stress
    for (int n = 0; n < 200; n++) begin
      lv2 = 1'($urandom_range(0, 1));
      ld2 = 2'($urandom);
      cyc();
    end
    lv2 = 0;
    repeat (4) cyc();

    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL drain%0d got %0d bits still expected, expected 0", k, exp_q[k].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
